wb_port_arbiter: RTL and testbench

Arbitrates the register-file write port between two writeback sources. Port 0 is the in-order pipeline WB stage and port 1 is a multi-cycle unit such as mul/div or a load-miss return. The block drives the select of the 32-bit 2:1 writeback MUX and registers the winning write toward the register file. Port 0 has priority, and an aging counter keeps port 1 from starving. When port 1 is forced in, the block asks the pipeline to stall.

---
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the in-order pipeline WB
//   stage (port 0) and a multi-cycle unit (port 1). Port 0 normally wins.
//   An aging counter forces port 1 through after MAX_WAIT denied cycles,
//   and the pipeline is stalled during that forced cycle. The winning write
//   is registered toward the register file, along with the MUX select.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/addr0/data0, ack0   pipeline WB write port
//   req1/addr1/data1, ack1   multi-cycle unit write port
//   stall_o                  hold pipeline WB stage (forced port 1 cycle)
//   sel_o                    registered MUX select (0 = port 0, 1 = port 1)
//   rf_we/rf_waddr/rf_wdata  registered register-file write
module wb_port_arbiter #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] data0,
   output logic          ack0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] data1,
   output logic          ack1,
   output logic          stall_o,
   output logic          sel_o,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata
);

   localparam int WC = $clog2(MAX_WAIT + 1);
   localparam logic [WC-1:0] MAX_WAIT_C = WC'(MAX_WAIT);

   logic [WC-1:0] wait_cnt_q, wait_cnt_d;
   logic          sel_q, sel_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;

   logic force_win;
   logic grant0, grant1;

   // Grants are suppressed during reset so a request pending across reset
   // is only accepted once rst is released.
   always_comb begin
      force_win = (wait_cnt_q == MAX_WAIT_C);
      grant1    = !rst && req1 && (!req0 || force_win);
      grant0    = !rst && req0 && !grant1;
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      sel_d      = sel_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_we_d    = 1'b0;

      // Aging: count denied cycles of a pending port 1 request, saturating.
      if (req1 && !grant1) begin
         if (!force_win) begin
            wait_cnt_d = wait_cnt_q + WC'(1);
         end
      end else begin
         wait_cnt_d = '0;
      end

      // x0 is hardwired zero: the write is consumed but never enabled.
      if (grant1) begin
         sel_d      = 1'b1;
         rf_waddr_d = addr1;
         rf_wdata_d = data1;
         rf_we_d    = (addr1 != '0);
      end else if (grant0) begin
         sel_d      = 1'b0;
         rf_waddr_d = addr0;
         rf_wdata_d = data0;
         rf_we_d    = (addr0 != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
         sel_q      <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         sel_q      <= sel_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign ack0     = grant0;
   assign ack1     = grant1;
   assign stall_o  = req0 && grant1;
   assign sel_o    = sel_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] data0, data1;
   logic          ack0, ack1, stall_o, sel_o, rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
      .stall_o(stall_o), .sel_o(sel_o),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past a rising edge; inputs set afterwards apply to the next cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_acks(input string tag, input logic a0, input logic a1, input logic st);
      #1;
      chk({tag, "_ack0"}, 32'(ack0), 32'(a0));
      chk({tag, "_ack1"}, 32'(ack1), 32'(a1));
      chk({tag, "_stall"}, 32'(stall_o), 32'(st));
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic sel,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      chk({tag, "_we"}, 32'(rf_we), 32'(we));
      chk({tag, "_sel"}, 32'(sel_o), 32'(sel));
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(wa));
      chk({tag, "_wdata"}, rf_wdata, wd);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
      addr0 = 5'd3; data0 = 32'h1111_1111;
      addr1 = 5'd4; data1 = 32'h2222_2222;

      // Reset held 3 cycles with both ports requesting
      for (int i = 0; i < 3; i++) begin
         chk_acks("rst", 1'b0, 1'b0, 1'b0);
         tick();
         chk_wr("rst", 1'b0, 1'b0, 5'd0, 32'h0);
      end
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      tick();

      // Port 0 only
      req0 = 1'b1; addr0 = 5'd5; data0 = 32'h0000_FFF0;
      chk_acks("p0", 1'b1, 1'b0, 1'b0);
      tick();
      req0 = 1'b0;
      chk_wr("p0", 1'b1, 1'b0, 5'd5, 32'h0000_FFF0);

      // Port 1 with port 0 idle
      req1 = 1'b1; addr1 = 5'd7; data1 = 32'hFFFF_FFFF;
      chk_acks("p1", 1'b0, 1'b1, 1'b0);
      tick();
      req1 = 1'b0;
      chk_wr("p1", 1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF);

      // Aging: port 0 continuous, port 1 raised at cycle 0
      req0 = 1'b1; req1 = 1'b1; addr1 = 5'd9; data1 = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         addr0 = 5'd3; data0 = 32'h0000_00A0 + 32'(i);
         chk_acks("age_deny", 1'b1, 1'b0, 1'b0);
         tick();
         chk_wr("age_deny", 1'b1, 1'b0, 5'd3, 32'h0000_00A0 + 32'(i));
      end
      chk_acks("age_force", 1'b0, 1'b1, 1'b1);
      tick();
      req1 = 1'b0;
      chk_wr("age_c5", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
      chk_acks("age_c5", 1'b1, 1'b0, 1'b0);
      tick();
      chk_wr("age_c6", 1'b1, 1'b0, 5'd3, 32'h0000_00A3);

      // Write to x0: consumed, rf_we stays low
      addr0 = 5'd0; data0 = 32'h00F0_F000;
      chk_acks("x0", 1'b1, 1'b0, 1'b0);
      tick();
      req0 = 1'b0;
      chk_wr("x0", 1'b0, 1'b0, 5'd0, 32'h00F0_F000);

      // Idle edge: write disabled, select/address/data hold
      chk_acks("idle", 1'b0, 1'b0, 1'b0);
      tick();
      chk_wr("idle", 1'b0, 1'b0, 5'd0, 32'h00F0_F000);

      // Reset mid-wait: build wait_cnt to 3, pulse reset, expect a full 4 denials
      req0 = 1'b1; addr0 = 5'd4; data0 = 32'h0000_0011;
      req1 = 1'b1; addr1 = 5'd12; data1 = 32'h0000_0022;
      for (int i = 0; i < 3; i++) begin
         chk_acks("mw_pre", 1'b1, 1'b0, 1'b0);
         tick();
      end
      rst = 1'b1;
      chk_acks("mw_rst", 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      chk_wr("mw_rst", 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk_acks("mw_deny", 1'b1, 1'b0, 1'b0);
         tick();
      end
      chk_acks("mw_force", 1'b0, 1'b1, 1'b1);
      tick();
      req1 = 1'b0;
      chk_wr("mw_force", 1'b1, 1'b1, 5'd12, 32'h0000_0022);
      req0 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
